md5_window_padder: RTL and testbench

- Sits between the command parser's text byte stream and the MD5 core.
- Keeps a sliding window of the last MSG_LEN received bytes.
- Each byte accepted once the window is full produces one MD5-padded 512-bit message block, tagged with the stream position of its last byte.
- The core hashes every MSG_LEN-byte substring of the text without the parser re-sending overlapping bytes.

---
 rtl/md5_pkg.sv | 15 +
 rtl/md5_pad_block.sv | 21 ++
 rtl/md5_window_padder.sv | 133 +++++++++++++
 tb/tb_md5_window_padder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared MD5 constants and the window padder state type.
// Holds block width, pad byte, length-field offset and default window length.
package md5_pkg;

    localparam int         MD5_BLOCK_W    = 512;
    localparam logic [7:0] MD5_PAD_BYTE   = 8'h80;
    localparam int         MD5_LEN_OFFSET = 56;
    localparam int         MD5_MSG_LEN    = 19;

    typedef enum logic {
        FILL,
        STREAM
    } pad_state_e;

endpackage

// File: rtl/md5_pad_block.sv
// Combinational padder: MSG_LEN-byte window -> one 512-bit MD5 block.
// Ports: window (oldest byte at bits [7:0]), block (byte i at [8*i +: 8]).
module md5_pad_block
    import md5_pkg::*;
#(
    parameter int MSG_LEN = MD5_MSG_LEN
) (
    input  logic [8*MSG_LEN-1:0]   window,
    output logic [MD5_BLOCK_W-1:0] block
);

    localparam logic [63:0] BIT_LEN = 64'(MSG_LEN * 8);

    always_comb begin
        block                         = '0;
        block[8*MSG_LEN-1:0]          = window;
        block[8*MSG_LEN +: 8]         = MD5_PAD_BYTE;
        block[8*MD5_LEN_OFFSET +: 64] = BIT_LEN;
    end

endmodule

// File: rtl/md5_window_padder.sv
// Sliding MSG_LEN-byte window over a text stream; emits one padded MD5 block
// per byte once full. Ports: clk, reset (async, active-low), clear,
// in_valid/in_data/in_ready, out_valid/out_block/out_pos/out_ready.
// Macro MD5_WINDOW_PADDER_STATS_EN adds blk_count (acknowledged blocks).
module md5_window_padder
    import md5_pkg::*;
#(
    parameter int MSG_LEN   = MD5_MSG_LEN,
    parameter int POS_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [MD5_BLOCK_W-1:0] out_block,
    output logic [POS_WIDTH-1:0]   out_pos,
    input  logic                   out_ready
`ifdef MD5_WINDOW_PADDER_STATS_EN
    ,
    output logic [31:0]            blk_count
`endif
);

    localparam int WIN_W  = 8 * MSG_LEN;
    localparam int FILL_W = $clog2(MSG_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(MSG_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(MSG_LEN);

    pad_state_e             state_q, state_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [WIN_W-1:0]       window_q, window_d;
    logic [POS_WIDTH-1:0]   pos_cnt_q;
    logic [1:0]             rst_sync_q;
    logic [MD5_BLOCK_W-1:0] padded;
    logic                   accept;
    logic                   emit;

    // Newest byte enters at the top; the oldest falls off the bottom.
    generate
        if (MSG_LEN == 1) begin : g_win1
            assign window_d = in_data;
        end else begin : g_winn
            assign window_d = {in_data, window_q[WIN_W-1:8]};
        end
    endgenerate

    md5_pad_block #(
        .MSG_LEN(MSG_LEN)
    ) u_pad (
        .window(window_d),
        .block (padded)
    );

    // Ready only after reset release has passed through the synchroniser.
    assign in_ready = rst_sync_q[1] && !clear &&
                      (state_q == FILL || !out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        emit    = 1'b0;
        if (accept) begin
            unique case (state_q)
                FILL: begin
                    if (fill_q == FILL_LAST) begin
                        state_d = STREAM;
                        fill_d  = FILL_FULL;
                        emit    = 1'b1;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                STREAM: emit = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= '0;
            state_q    <= FILL;
            fill_q     <= '0;
            window_q   <= '0;
            pos_cnt_q  <= '0;
            out_valid  <= 1'b0;
            out_block  <= '0;
            out_pos    <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
            if (clear) begin
                state_q   <= FILL;
                fill_q    <= '0;
                window_q  <= '0;
                pos_cnt_q <= '0;
                out_valid <= 1'b0;
                out_block <= '0;
                out_pos   <= '0;
            end else begin
                state_q <= state_d;
                fill_q  <= fill_d;
                if (accept) begin
                    window_q  <= window_d;
                    pos_cnt_q <= pos_cnt_q + 1'b1;
                end
                if (emit) begin
                    out_valid <= 1'b1;
                    out_block <= padded;
                    out_pos   <= pos_cnt_q;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

`ifdef MD5_WINDOW_PADDER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_count <= '0;
        end else if (clear) begin
            blk_count <= '0;
        end else if (out_valid && out_ready && blk_count != 32'hFFFF_FFFF) begin
            blk_count <= blk_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_md5_window_padder.sv
// Scoreboard bench for md5_window_padder (MSG_LEN=19, POS_WIDTH=16).
// Builds expected blocks from its own byte history and compares on handshake.
module tb_md5_window_padder;

    localparam int ML = 19;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [15:0]  pos;
        logic [511:0] blk;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [511:0] out_block;
    logic [15:0]  out_pos;
    logic         out_ready = 1'b1;
`ifdef MD5_WINDOW_PADDER_STATS_EN
    logic [31:0]  blk_count;
`endif

    int n_checks = 0;
    int n_err    = 0;

    md5_window_padder #(
        .MSG_LEN  (ML),
        .POS_WIDTH(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_block(out_block),
        .out_pos  (out_pos),
        .out_ready(out_ready)
`ifdef MD5_WINDOW_PADDER_STATS_EN
        ,
        .blk_count(blk_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mk_block(input byte_q_t q);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < ML; i++) b[8*i +: 8] = q[i];
        b[8*ML +: 8] = 8'h80;
        b[8*56 +: 8] = 8'h98;
        return b;
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle.
    byte_q_t      hist;
    exp_t         sb[$];
    logic [15:0]  mpos = '0;
    logic         exp_valid = 1'b0;
    logic         stalled = 1'b0;
    logic [511:0] held_blk;
    logic [15:0]  held_pos;
    logic [15:0]  last_ack_pos = '0;
    logic         saw_wrap = 1'b0;
    int           rcnt = 0;
    int           acks = 0;

    always @(negedge clk) begin
        logic nxt;
        exp_t e;
        if (!reset) begin
            hist.delete();
            sb.delete();
            mpos      = '0;
            exp_valid = 1'b0;
            stalled   = 1'b0;
            rcnt      = 0;
            acks      = 0;
        end else begin
            if (rcnt < 3) rcnt++;
            chk("out_valid", 512'(out_valid), 512'(exp_valid));
            if (rcnt >= 3)
                chk("in_ready", 512'(in_ready),
                    512'(!clear && (!out_valid || out_ready)));
            else
                chk("in_ready_sync", 512'(in_ready), 512'(0));
            if (stalled) begin
                chk("hold_pos", 512'(out_pos), 512'(held_pos));
                chk("hold_blk", out_block, held_blk);
            end
            nxt = exp_valid;
            if (out_valid && out_ready) begin
                acks++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 512'(1), 512'(0));
                end else begin
                    e = sb.pop_front();
                    chk("out_pos", 512'(out_pos), 512'(e.pos));
                    chk("out_block", out_block, e.blk);
                end
                if (last_ack_pos == 16'hFFFF && out_pos == 16'h0000)
                    saw_wrap = 1'b1;
                last_ack_pos = out_pos;
                nxt = 1'b0;
            end
            stalled  = out_valid && !out_ready;
            held_blk = out_block;
            held_pos = out_pos;
            if (clear) begin
                hist.delete();
                sb.delete();
                mpos    = '0;
                nxt     = 1'b0;
                stalled = 1'b0;
            end else if (in_valid && in_ready) begin
                hist.push_back(in_data);
                if (hist.size() > ML) void'(hist.pop_front());
                if (hist.size() == ML) begin
                    e.pos = mpos;
                    e.blk = mk_block(hist);
                    sb.push_back(e);
                    nxt = 1'b1;
                end
                mpos = mpos + 16'd1;
            end
            exp_valid = nxt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        logic acc;
        int   n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 512'(1), 512'(0));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    string s1 = "123456789ABCDEF0123";

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 512'(in_ready), 512'(0));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_out_block", out_block, 512'(0));
        chk("rst_out_pos", 512'(out_pos), 512'(0));
        reset = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < ML; i++) send(s1[i]);
        @(negedge clk);
        chk("first_valid", 512'(out_valid), 512'(1));
        chk("first_pos", 512'(out_pos), 512'(18));
        chk("first_b0", 512'(out_block[7:0]), 512'(8'h31));
        chk("first_pad", 512'(out_block[8*19 +: 8]), 512'(8'h80));
        chk("first_len", 512'(out_block[8*56 +: 8]), 512'(8'h98));
        tick();

        send("X");
        @(negedge clk);
        chk("lat_valid", 512'(out_valid), 512'(1));
        chk("lat_pos", 512'(out_pos), 512'(19));
        chk("lat_b0", 512'(out_block[7:0]), 512'(8'h32));
        tick();

        out_ready = 1'b0;
        send("Y");
        in_valid = 1'b1;
        in_data  = "Z";
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_rdy", 512'(in_ready), 512'(0));
        end
        tick();
        out_ready = 1'b1;
        send("Z");
        send("W");
        send("V");
        repeat (2) tick();

        out_ready = 1'b0;
        send("a");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("clr_valid", 512'(out_valid), 512'(0));
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < ML - 1; i++) send(8'(8'h41 + i));
        repeat (3) tick();
        send("q");
        @(negedge clk);
        chk("clr_pos", 512'(out_pos), 512'(18));
        tick();

        for (int i = 0; i < 65554; i++) send(8'(i * 7));
        repeat (3) tick();
        chk("pos_wrap", 512'(saw_wrap), 512'(1));

        out_ready = 1'b0;
        send("r");
        #2;
        reset = 1'b0;
        #1;
        chk("arst_in_ready", 512'(in_ready), 512'(0));
        chk("arst_valid", 512'(out_valid), 512'(0));
        chk("arst_block", out_block, 512'(0));
        chk("arst_pos", 512'(out_pos), 512'(0));
`ifdef MD5_WINDOW_PADDER_STATS_EN
        chk("arst_count", 512'(blk_count), 512'(0));
`endif
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < ML + 4; i++) send(8'(8'hC0 + i));
        repeat (3) tick();
        chk("acks_after_rst", 512'(acks), 512'(5));
`ifdef MD5_WINDOW_PADDER_STATS_EN
        chk("blk_count", 512'(blk_count), 512'(5));
`endif
        chk("sb_drained", 512'(sb.size()), 512'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
